conv55_6bit_feeder: RTL and testbench
=====================================

// Module: conv55_6bit_feeder
// PURPOSE
//  Operand loader and result collector for the 5x5 6-bit convolution block.
//  Accepts a serial 6-bit word stream and fills a 25-tap kernel bank and a 25-tap data window.
//  Drives both onto the conv block's parallel inputs and samples its 18-bit result.
//  Returns the result on a valid/ready stream. Sits between the PIM tile buffer and the conv block.
// PARAMETERS
//  DW        6   operand width (bits per tap)
//  TAPS      25  taps per window (5x5)
//  OW        18  result width
//  CONV_LAT  1   cycles from window-complete to result sample; legal range 1..15
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        reset, asynchronous assert, active low
//  cmd_valid    in   1        start request
//  cmd_ready    out  1        high only in IDLE
//  cmd_kload    in   1        1: load TAPS kernel words then TAPS data words; 0: data only, kernel retained
//  s_valid      in   1        operand word valid
//  s_ready      out  1        high only in LOAD_K / LOAD_D
//  s_data       in   DW       operand word; first word of each bank goes to tap 0
//  win_data     out  TAPS*DW  tap i at [i*DW +: DW]; to conv in_data_i
//  win_kern     out  TAPS*DW  tap i at [i*DW +: DW]; to conv kernel_i
//  conv_result  in   OW       conv block out_data
//  m_valid      out  1        result valid
//  m_ready      in   1        result accepted
//  m_data       out  OW       captured result
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state IDLE; tap counter 0; latency counter 0
//   - both banks all-zero; m_data 0; m_valid 0; s_ready 0; cmd_ready 1; busy 0
//  FSM states and transitions:
//   - IDLE:   cmd handshake with cmd_kload=1 -> LOAD_K; cmd_kload=0 -> LOAD_D.
//   - LOAD_K: each s_valid&s_ready writes kern[cnt] and increments cnt.
//             The 25th beat (cnt==TAPS-1) clears cnt and moves to LOAD_D.
//   - LOAD_D: same handshake into data[cnt]; the 25th beat moves to WAIT with lat=0.
//   - WAIT:   lat increments each cycle. On the cycle lat==CONV_LAT-1:
//             m_data <= conv_result, m_valid <= 1, state -> OUT.
//   - OUT:    hold m_valid/m_data stable until m_ready; on handshake m_valid <= 0, state -> IDLE.
//  Timing:
//   - Latency: last data beat to m_valid high = CONV_LAT+1 cycles.
//   - Banks are written only on accepted beats. win_* change only in LOAD_*.
//   - win_* are stable throughout WAIT and OUT.
//   - Partial windows are visible during LOAD; conv_result is sampled only in WAIT.
//  Boundary conditions:
//   - s_valid low stalls the load. The counter holds and no timeout applies.
//   - A cmd presented outside IDLE is ignored (cmd_ready low).
//     No bypass: after an OUT handshake, cmd_ready rises the next cycle.
//   - cmd_kload=0 with no prior kernel load uses the reset (zero) kernel. This is legal, not an error.
//   - Kernel bank persists across commands. Data bank is fully rewritten every command.
//   - rst_n assertion mid-operation: immediate return to IDLE, both banks cleared, m_valid dropped.
//     Any partial load is discarded.
//   - m_ready high while m_valid is low has no effect.
// STRUCTURE
//  - Shared package conv55_pkg: DW, TAPS, OW constants and a state enum
//    {IDLE, LOAD_K, LOAD_D, WAIT, OUT} as 3-bit localparams. The conv block and this feeder both import it.
//  - One natural sub-module, conv55_tap_bank: a TAPS x DW register bank with write enable,
//    5-bit index, async clear, and a flat output bus. It is instantiated twice (kernel, data).
//  - Tap counter is 5 bits, latency counter 4 bits; both are shared across states.
// TESTING  (bench instantiates the real conv block; its result = zero-extended OR of all 50 operands)
//  1. Kernel load: cmd_kload=1, kern words all 6'h01, data words all 6'h00.
//     -> m_data=18'h00001 exactly 2 cycles after the 50th beat; win_kern all 6'h01.
//  2. Data-only reuse: follow test 1 with cmd_kload=0 and data tap 24 = 6'h20, others 0.
//     -> m_data=18'h00021 and the kernel bank is unchanged.
//  3. Backpressure: s_valid toggled 1/0 every cycle and m_ready held low 10 cycles.
//     -> exactly 50 beats accepted; m_valid and m_data hold for all 10 cycles;
//        cmd_ready stays low until the handshake.
//  4. Reset mid-load: assert rst_n=0 after 30 beats.
//     -> win_kern and win_data read 0; state IDLE; a following data-only command yields m_data=0.
//  5. Command while busy: cmd_valid held high throughout test 1.
//     -> the second command is accepted only in the cycle after the m_valid/m_ready handshake.
//  6. CONV_LAT=4 build: repeat test 1.
//     -> m_valid rises 5 cycles after the last beat; the conv_result sample is taken in the final WAIT cycle.

Source files
------------

// File: rtl/conv55_pkg.sv
// conv55_pkg
//   Constants and state encoding shared by the 5x5 6-bit convolution block
//   and its operand feeder.
//   DW       operand width, one tap
//   TAPS     taps per 5x5 window
//   OW       convolution result width
//   CW / LW  widths of the feeder's tap counter and latency counter
//   state_e  feeder FSM states; the codes are also available as ST_* localparams

package conv55_pkg;

    localparam int DW   = 6;
    localparam int TAPS = 25;
    localparam int OW   = 18;
    localparam int CW   = 5;
    localparam int LW   = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_K = 3'd1;
    localparam logic [2:0] ST_LOAD_D = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD_K = ST_LOAD_K,
        LOAD_D = ST_LOAD_D,
        WAIT   = ST_WAIT,
        OUT    = ST_OUT
    } state_e;

endpackage

// File: rtl/conv55_tap_bank.sv
// conv55_tap_bank
//   TAPS x DW register bank. One tap is written per cycle at index idx_i when
//   we_i is high; all taps are driven in parallel on a flat bus.
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low clear of every tap
//     we_i     in   write enable
//     idx_i    in   5-bit tap index; values >= TAPS are ignored
//     wdata_i  in   DW-bit word for the addressed tap
//     bank_o   out  TAPS*DW flat bus, tap i at [i*DW +: DW]

module conv55_tap_bank
    import conv55_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [CW-1:0]        idx_i,
    input  logic [DW-1:0]        wdata_i,
    output logic [TAPS*DW-1:0]   bank_o
);

    // Packed so that tap i lands at [i*DW +: DW] of the flat view.
    logic [TAPS-1:0][DW-1:0] tap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '0;
        end else if (we_i && (idx_i < CW'(TAPS))) begin
            tap_q[idx_i] <= wdata_i;
        end
    end

    assign bank_o = tap_q;

endmodule

// File: rtl/conv55_6bit_feeder.sv
// conv55_6bit_feeder
//   Operand loader and result collector for the 5x5 6-bit convolution block.
//   A command optionally loads a 25-word kernel, then always loads a 25-word
//   data window from a serial word stream. Both banks drive the conv block's
//   parallel inputs; CONV_LAT cycles after the window is complete the conv
//   result is captured and offered on a valid/ready output stream.
//   Parameter:
//     CONV_LAT     cycles from window-complete to result sample, 1..15
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     cmd_valid    in   start request
//     cmd_ready    out  high only in IDLE
//     cmd_kload    in   1: kernel then data load, 0: data only (kernel kept)
//     s_valid      in   operand word valid
//     s_ready      out  high only while loading
//     s_data       in   operand word, first word of each bank goes to tap 0
//     win_data     out  data window, tap i at [i*DW +: DW]
//     win_kern     out  kernel bank, tap i at [i*DW +: DW]
//     conv_result  in   conv block result
//     m_valid      out  result valid
//     m_ready      in   result accepted
//     m_data       out  captured result
//     busy         out  state != IDLE
//
//   Every handshake (cmd_*, s_*, m_*) transfers on a rising clock edge where
//   valid and ready are both high; valid must not depend on ready, and an
//   offered m_valid/m_data stays stable until it is taken.

module conv55_6bit_feeder
    import conv55_pkg::*;
#(
    parameter int CONV_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_kload,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    output logic [TAPS*DW-1:0]   win_data,
    output logic [TAPS*DW-1:0]   win_kern,
    input  logic [OW-1:0]        conv_result,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OW-1:0]        m_data,
    output logic                 busy
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TAPS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(CONV_LAT - 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [LW-1:0]   lat_q;
    logic            cmd_ready_q;
    logic            s_ready_q;
    logic            busy_q;
    logic            m_valid_q;
    logic [OW-1:0]   m_data_q;

    logic            beat;
    logic            kern_we;
    logic            data_we;

    // A beat is an accepted stream word; s_ready_q is only high in LOAD_*.
    assign beat    = s_valid && s_ready_q;
    assign kern_we = beat && (state_q == LOAD_K);
    assign data_we = beat && (state_q == LOAD_D);

    conv55_tap_bank u_kern_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (kern_we),
        .idx_i   (cnt_q),
        .wdata_i (s_data),
        .bank_o  (win_kern)
    );

    conv55_tap_bank u_data_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (data_we),
        .idx_i   (cnt_q),
        .wdata_i (s_data),
        .bank_o  (win_data)
    );

    // Control FSM. The handshake outputs are registered and are updated in
    // the same branch that changes the state, so they always match it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_q       <= '0;
            cmd_ready_q <= 1'b1;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q     <= cmd_kload ? LOAD_K : LOAD_D;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                LOAD_K: begin
                    if (beat) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= LOAD_D;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end

                LOAD_D: begin
                    if (beat) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q     <= '0;
                            lat_q     <= '0;
                            s_ready_q <= 1'b0;
                            state_q   <= WAIT;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end

                WAIT: begin
                    // The windows are frozen here, so conv_result settles;
                    // it is sampled in the last of the CONV_LAT wait cycles.
                    if (lat_q == LAT_LAST) begin
                        lat_q     <= '0;
                        m_data_q  <= conv_result;
                        m_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end else begin
                        lat_q <= lat_q + LW'(1);
                    end
                end

                OUT: begin
                    if (m_ready) begin
                        m_valid_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    lat_q       <= '0;
                    cmd_ready_q <= 1'b1;
                    s_ready_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    m_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign s_ready   = s_ready_q;
    assign busy      = busy_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;

endmodule

// File: tb/tb_conv55_6bit_feeder.sv
// Bench for conv55_6bit_feeder. Two instances: index 0 built with CONV_LAT=1,
// index 1 built with CONV_LAT=4. Each is wired to a behavioural conv block
// whose result is the zero-extended OR of all 50 operands.

module tb_conv55_6bit_feeder;
    import conv55_pkg::*;

    localparam int BW = TAPS * DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [1:0]                 cmd_valid, cmd_ready, cmd_kload;
    logic [1:0]                 s_valid, s_ready;
    logic [1:0][DW-1:0]         s_data;
    logic [1:0][BW-1:0]         win_data, win_kern;
    logic [1:0][OW-1:0]         conv_result, m_data;
    logic [1:0]                 m_valid, m_ready, busy;

    function automatic logic [OW-1:0] conv_model(input logic [BW-1:0] k, input logic [BW-1:0] x);
        logic [DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < TAPS; i++) acc = acc | k[i*DW +: DW] | x[i*DW +: DW];
        return {{(OW-DW){1'b0}}, acc};
    endfunction

    assign conv_result[0] = conv_model(win_kern[0], win_data[0]);
    assign conv_result[1] = conv_model(win_kern[1], win_data[1]);

    conv55_6bit_feeder #(.CONV_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_kload(cmd_kload[0]),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .win_data(win_data[0]), .win_kern(win_kern[0]), .conv_result(conv_result[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .busy(busy[0])
    );

    conv55_6bit_feeder #(.CONV_LAT(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_kload(cmd_kload[1]),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .win_data(win_data[1]), .win_kern(win_kern[1]), .conv_result(conv_result[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .busy(busy[1])
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [OW-1:0] exp_q[$];      // results expected from instance 0
    logic [OW-1:0] exp_q_l4[$];   // results expected from instance 1

    logic [1:0][BW-1:0] kmodel;
    int last_beat_cyc[2];
    int hs_cyc[2];
    int acc_cyc[2];
    int acc_cnt[2];
    int beat_cnt[2];
    logic [1:0]         prev_mv, prev_mr;
    logic [1:0][OW-1:0] prev_md;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (m_valid[d] && !prev_mv[d])
                    check("latency", BW'(cyc - last_beat_cyc[d]), (d == 1) ? BW'(5) : BW'(2));
                if (prev_mv[d] && !prev_mr[d]) begin
                    check("hold_valid", BW'(m_valid[d]), BW'(1));
                    check("hold_data", BW'(m_data[d]), BW'(prev_md[d]));
                end
                check("cmd_ready_vs_busy", BW'(cmd_ready[d]), BW'(!busy[d]));
                if (m_valid[d] && m_ready[d]) begin
                    hs_cyc[d] <= cyc;
                    if (d == 0) begin
                        if (exp_q.size() == 0) check("unexpected_result", BW'(1), BW'(0));
                        else check("result", BW'(m_data[d]), BW'(exp_q.pop_front()));
                    end else begin
                        if (exp_q_l4.size() == 0) check("unexpected_result_l4", BW'(1), BW'(0));
                        else check("result_l4", BW'(m_data[d]), BW'(exp_q_l4.pop_front()));
                    end
                end
                if (cmd_valid[d] && cmd_ready[d]) begin
                    acc_cnt[d] <= acc_cnt[d] + 1;
                    acc_cyc[d] <= cyc;
                end
                if (s_valid[d] && s_ready[d]) beat_cnt[d] <= beat_cnt[d] + 1;
            end
        end
        prev_mv <= rst_n ? m_valid : 2'b00;
        prev_mr <= m_ready;
        prev_md <= m_data;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] fill_bus(input logic [DW-1:0] v, input int tap, input logic [DW-1:0] tv);
        logic [BW-1:0] b;
        for (int i = 0; i < TAPS; i++) b[i*DW +: DW] = v;
        if (tap >= 0) b[tap*DW +: DW] = tv;
        return b;
    endfunction

    task automatic do_cmd(input int d, input logic kl);
        int n;
        n = 0;
        cmd_valid[d] = 1'b1;
        cmd_kload[d] = kl;
        while (!cmd_ready[d] && n < 200) begin
            step();
            n++;
        end
        check("cmd_accept_timeout", BW'(cmd_ready[d]), BW'(1));
        step();
        cmd_valid[d] = 1'b0;
    endtask

    task automatic load_bank(input int d, input logic [BW-1:0] bus, input bit toggle, input int nbeats);
        int i, n;
        bit ph;
        i = 0; n = 0; ph = 1'b0;
        while (i < nbeats && n < 2000) begin
            if (toggle && ph) begin
                s_valid[d] = 1'b0;
            end else begin
                s_valid[d] = 1'b1;
                s_data[d]  = bus[i*DW +: DW];
                if (s_ready[d]) begin
                    last_beat_cyc[d] = cyc;
                    i++;
                end
            end
            ph = !ph;
            step();
            n++;
        end
        s_valid[d] = 1'b0;
        check("load_beats", BW'(i), BW'(nbeats));
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy[d] && n < 200) begin
            step();
            n++;
        end
        check("idle_timeout", BW'(busy[d]), BW'(0));
    endtask

    task automatic push_exp(input int d, input logic [OW-1:0] res);
        if (d == 0) exp_q.push_back(res);
        else exp_q_l4.push_back(res);
    endtask

    task automatic run_cmd(input int d, input logic kl, input logic [BW-1:0] kb,
                           input logic [BW-1:0] db, input logic [OW-1:0] res);
        do_cmd(d, kl);
        if (kl) begin
            load_bank(d, kb, 1'b0, TAPS);
            kmodel[d] = kb;
        end
        load_bank(d, db, 1'b0, TAPS);
        push_exp(d, res);
        wait_idle(d);
        check("win_kern", win_kern[d], kmodel[d]);
        check("win_data", win_data[d], db);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          kload;
        logic [DW-1:0] kfill;
        logic [DW-1:0] dfill;
        int            dtap;
        logic [DW-1:0] dval;
        logic [OW-1:0] res;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] kcur, dv, tv;
        int tp, a0, b0, n;

        vecs[0] = '{kload: 1'b1, kfill: 6'h01, dfill: 6'h00, dtap: -1, dval: 6'h00, res: 18'h00001};
        vecs[1] = '{kload: 1'b0, kfill: 6'h00, dfill: 6'h00, dtap: 24, dval: 6'h20, res: 18'h00021};
        vecs[2] = '{kload: 1'b1, kfill: 6'h00, dfill: 6'h00, dtap: -1, dval: 6'h00, res: 18'h00000};
        vecs[3] = '{kload: 1'b0, kfill: 6'h00, dfill: 6'h3f, dtap: -1, dval: 6'h00, res: 18'h0003f};
        vecs[4] = '{kload: 1'b1, kfill: 6'h2a, dfill: 6'h00, dtap: 0,  dval: 6'h05, res: 18'h0002f};
        vecs[5] = '{kload: 1'b1, kfill: 6'h10, dfill: 6'h00, dtap: 12, dval: 6'h03, res: 18'h00013};
        vecs[6] = '{kload: 1'b0, kfill: 6'h00, dfill: 6'h00, dtap: 7,  dval: 6'h08, res: 18'h00018};
        vecs[7] = '{kload: 1'b0, kfill: 6'h00, dfill: 6'h11, dtap: -1, dval: 6'h00, res: 18'h00011};

        rst_n = 1'b0;
        cmd_valid = '0; cmd_kload = '0; s_valid = '0; s_data = '0; m_ready = 2'b11;
        kmodel = '0;
        for (int d = 0; d < 2; d++) begin
            last_beat_cyc[d] = 0; hs_cyc[d] = 0; acc_cyc[d] = 0; acc_cnt[d] = 0; beat_cnt[d] = 0;
        end

        // reset state
        #12;
        check("rst_win_kern", win_kern[0], '0);
        check("rst_win_data", win_data[0], '0);
        check("rst_m_valid", BW'(m_valid[0]), BW'(0));
        check("rst_m_data", BW'(m_data[0]), BW'(0));
        check("rst_s_ready", BW'(s_ready[0]), BW'(0));
        check("rst_cmd_ready", BW'(cmd_ready[0]), BW'(1));
        check("rst_busy", BW'(busy[0]), BW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // table-driven commands (first two are kernel load and data-only reuse)
        kcur = '0;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].kload) kcur = vecs[v].kfill;
            run_cmd(0, vecs[v].kload, fill_bus(vecs[v].kfill, -1, 6'h00),
                    fill_bus(vecs[v].dfill, vecs[v].dtap, vecs[v].dval), vecs[v].res);
        end

        // random data-only commands against the retained kernel
        for (int r = 0; r < 4; r++) begin
            dv = DW'($urandom_range(0, 63));
            tp = $urandom_range(0, TAPS - 1);
            tv = DW'($urandom_range(0, 63));
            run_cmd(0, 1'b0, '0, fill_bus(dv, tp, tv), OW'(kcur | dv | tv));
        end

        // backpressure: s_valid toggles, m_ready low for 10 cycles
        m_ready[0] = 1'b0;
        b0 = beat_cnt[0];
        do_cmd(0, 1'b1);
        load_bank(0, fill_bus(6'h04, -1, 6'h00), 1'b1, TAPS);
        kmodel[0] = fill_bus(6'h04, -1, 6'h00);
        load_bank(0, fill_bus(6'h00, 3, 6'h08), 1'b1, TAPS);
        push_exp(0, 18'h0000c);
        check("bp_beats", BW'(beat_cnt[0] - b0), BW'(50));
        n = 0;
        while (!m_valid[0] && n < 50) begin
            step();
            n++;
        end
        check("bp_m_valid", BW'(m_valid[0]), BW'(1));
        for (int i = 0; i < 10; i++) begin
            check("bp_cmd_ready_low", BW'(cmd_ready[0]), BW'(0));
            step();
        end
        check("bp_still_valid", BW'(m_valid[0]), BW'(1));
        m_ready[0] = 1'b1;
        wait_idle(0);
        kcur = 6'h04;

        // command held high: second accept exactly one cycle after the handshake
        a0 = acc_cnt[0];
        cmd_kload[0] = 1'b1;
        cmd_valid[0] = 1'b1;
        n = 0;
        while (acc_cnt[0] == a0 && n < 50) begin
            step();
            n++;
        end
        cmd_kload[0] = 1'b0;
        load_bank(0, fill_bus(6'h01, -1, 6'h00), 1'b0, TAPS);
        kmodel[0] = fill_bus(6'h01, -1, 6'h00);
        load_bank(0, fill_bus(6'h00, -1, 6'h00), 1'b0, TAPS);
        push_exp(0, 18'h00001);
        n = 0;
        while (acc_cnt[0] == a0 + 1 && n < 100) begin
            step();
            n++;
        end
        check("busy_cmd_accept_cycle", BW'(acc_cyc[0] - hs_cyc[0]), BW'(1));
        cmd_valid[0] = 1'b0;
        load_bank(0, fill_bus(6'h00, -1, 6'h00), 1'b0, TAPS);
        push_exp(0, 18'h00001);
        wait_idle(0);
        check("busy_accept_count", BW'(acc_cnt[0] - a0), BW'(2));
        check("busy_kern_kept", win_kern[0], kmodel[0]);

        // reset after 30 beats
        do_cmd(0, 1'b1);
        load_bank(0, fill_bus(6'h2a, -1, 6'h00), 1'b0, TAPS);
        load_bank(0, fill_bus(6'h15, -1, 6'h00), 1'b0, 5);
        rst_n = 1'b0;
        #2;
        kmodel = '0;
        check("mid_rst_win_kern", win_kern[0], '0);
        check("mid_rst_win_data", win_data[0], '0);
        check("mid_rst_busy", BW'(busy[0]), BW'(0));
        check("mid_rst_cmd_ready", BW'(cmd_ready[0]), BW'(1));
        check("mid_rst_s_ready", BW'(s_ready[0]), BW'(0));
        check("mid_rst_m_valid", BW'(m_valid[0]), BW'(0));
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_cmd(0, 1'b0, '0, fill_bus(6'h00, -1, 6'h00), 18'h00000);

        // CONV_LAT=4 instance: kernel load then data-only reuse
        run_cmd(1, 1'b1, fill_bus(6'h01, -1, 6'h00), fill_bus(6'h00, -1, 6'h00), 18'h00001);
        run_cmd(1, 1'b0, '0, fill_bus(6'h00, 24, 6'h20), 18'h00021);

        step();
        check("exp_q_drained", BW'(exp_q.size()), BW'(0));
        check("exp_q_l4_drained", BW'(exp_q_l4.size()), BW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
